// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer shared by instruction fetch (IF) and load/store (D) requesters.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate ties between requesters instead of D always winning.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,

    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_we,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,

    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_we,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic              OWNER_IF  = 1'b0;
    localparam logic              OWNER_D   = 1'b1;
    localparam logic [3:0]        LAT_M1    = 4'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must be within 1..15");
    end
    if (ADDR_W < 3) begin : g_bad_addr_w
        $error("mem_port_arbiter: ADDR_W must be at least 3");
    end

    state_t            state_reg, state_next;
    logic              owner_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        we_reg;
    logic [3:0]        cnt_reg, cnt_next;

    logic              grant_any;
    logic              grant_d;
    logic              grant_if;
    logic              tie_pick_d;
    logic              is_load;

    logic [1:0]        resp_valid;
    logic [1:0][31:0]  resp_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_owner_reg;

    // On a tie, the requester that did not own the previous access wins.
    assign tie_pick_d = ~last_owner_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_reg <= OWNER_IF;
        end else if (grant_any) begin
            last_owner_reg <= grant_d;
        end
    end
`else
    assign tie_pick_d = 1'b1;
`endif

    // Arbitration: only in IDLE and never while reset is held.
    always_comb begin
        grant_any = rst && (state_reg == S_IDLE) && (if_req || d_req);
        grant_d   = grant_any && d_req && (!if_req || tie_pick_d);
        grant_if  = grant_any && if_req && !grant_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            owner_reg <= OWNER_IF;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (grant_d) begin
                owner_reg <= OWNER_D;
                addr_reg  <= d_addr;
                wdata_reg <= d_wdata;
                we_reg    <= d_we;
            end else if (grant_if) begin
                owner_reg <= OWNER_IF;
                addr_reg  <= if_addr;
                wdata_reg <= '0;
                we_reg    <= '0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (grant_any) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_next = LAT_M1;
                if (MEM_LAT == 1) begin
                    state_next = S_RESP;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Address and store data stay on the bus through WAIT; strobes only in ISSUE.
    always_comb begin
        if_gnt    = grant_if;
        d_gnt     = grant_d;
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_reg == S_ISSUE || state_reg == S_WAIT) begin
            mem_addr  = addr_reg & ADDR_MASK;
            mem_wdata = wdata_reg;
        end
        if (state_reg == S_ISSUE) begin
            mem_en = 1'b1;
            mem_we = we_reg;
        end
    end

    assign is_load = (we_reg == 4'h0);

    // Index 0 is the fetch port, index 1 the data port.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign resp_valid[gi] = (state_reg == S_RESP) && (owner_reg == (gi == 1));
        assign resp_data[gi]  = (resp_valid[gi] && is_load) ? mem_rdata : 32'h0;
    end

    assign if_rvalid = resp_valid[0];
    assign if_rdata  = resp_data[0];
    assign d_rvalid  = resp_valid[1];
    assign d_rdata   = resp_data[1];

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single-port word memory shared by two requesters of the multicycle RV32IM datapath: instruction fetch (IF) and load/store (D).
- Accepts one request at a time, drives the memory for a fixed-latency access, then returns a completion/read-data pulse to the granted requester.
- Sits between the datapath and the memory in the processor top level, in place of the dual-port imem/dmem split.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from mem_en high to mem_rdata valid; legal range 1..15.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  processor clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held with stable if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  fetched instruction.
- d_req  in  1  data request; held with stable d_addr/d_wdata/d_we until d_gnt.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data, already lane-aligned.
- d_we  in  4  byte write enables; 0 means load.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle completion pulse for load or store.
- d_rdata  out  32  load word; 0 on store completion.
- mem_en  out  1  memory access strobe.
- mem_addr  out  ADDR_W  word-aligned address: {addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  store data.
- mem_we  out  4  byte write enables; nonzero only while mem_en=1.
- mem_rdata  in  32  memory read data.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset: state=IDLE. All outputs are 0 during reset and in IDLE, except the combinational gnt.
- IDLE:
  - Grant arbitration is combinational in the same cycle.
  - Only one of if_req/d_req high: that requester gets gnt=1.
  - Both high: d wins (fixed priority).
  - On the edge, owner, address, wdata and we are latched, and state goes to ISSUE. Requester inputs are ignored after gnt.
- ISSUE (1 cycle): mem_en=1, with mem_addr/mem_wdata/mem_we driven from the latched values.
  - MEM_LAT=1: go to RESP.
  - MEM_LAT>1: load down-counter with MEM_LAT-1 and go to WAIT.
- WAIT: mem_en=0, mem_we=0. The counter decrements each cycle; at 1, go to RESP.
- RESP (1 cycle):
  - Owner's rvalid=1.
  - Owner's rdata = mem_rdata for a load (pass-through), 32'h0 for a store.
  - The non-owner's rvalid stays 0.
  - Next state is IDLE.
- Timing: with gnt in cycle T, mem_en is in T+1 and rvalid in T+1+MEM_LAT. The earliest next gnt is T+2+MEM_LAT. Throughput is one access per MEM_LAT+2 cycles.
- Grants are never issued outside IDLE. A request arriving in ISSUE/WAIT/RESP waits; no request is lost if held.
- rdata outputs are 0 whenever their rvalid is 0.
- Misaligned addresses: bits [1:0] are dropped on mem_addr. Lane selection is the requester's job.
- Reset asserted mid-access: immediate return to IDLE. mem_en/mem_we drop asynchronously, no rvalid is issued, and the access is abandoned. Requesters must re-request after reset.
- Counter width is 4 bits; MEM_LAT outside 1..15 is a configuration error.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_owner register is added (reset 0 = IF). On simultaneous requests in IDLE, the requester that was not last_owner wins. last_owner updates on every grant.
- Undefined: fixed priority, D always wins ties; no last_owner register.

Test Plan:
- Fetch only, MEM_LAT=1:
  - Stimulus: if_req=1, if_addr=32'h0000_0104, memory word at 0x104 = 32'h0000_0513.
  - Required: if_gnt in cycle T; mem_en=1 with mem_addr=0x104 in T+1; if_rvalid=1 with if_rdata=32'h0000_0513 in T+2; d_rvalid stays 0.
- Store, MEM_LAT=3:
  - Stimulus: d_req=1, d_addr=0x203, d_we=4'b1000, d_wdata=32'hAB00_0000.
  - Required: mem_addr=0x200 and mem_we=4'b1000 for exactly one cycle (T+1); d_rvalid=1 with d_rdata=0 at T+4; mem_we=0 in T+2..T+4.
- Simultaneous requests, macro undefined:
  - Stimulus: if_req and d_req both high and held.
  - Required: d_gnt first; if_gnt at T+3 (MEM_LAT=1); two completions, D first.
- Simultaneous requests, MEM_ARB_ROUND_ROBIN_EN defined:
  - Stimulus: both requests held for four accesses.
  - Required: grant order D, IF, D, IF.
- Request during busy:
  - Stimulus: d_req rises in the ISSUE cycle of a fetch.
  - Required: no d_gnt until the IDLE cycle after if_rvalid; the load then completes correctly.
- Reset mid-access:
  - Stimulus: rst=0 asserted during WAIT (MEM_LAT=4).
  - Required: mem_en, mem_we and both rvalid outputs go 0 immediately; no rvalid after reset release; a new if_req is granted in the first IDLE cycle.
